ram_bus_ctrl: RTL and testbench

- Bus master for the word-pair RAM (10-bit words, 20-bit shared inout data bus, a read returns the aligned even/odd pair).
- Accepts single-word read/write requests from the datapath through a valid/ready handshake.
- Sequences `ram_we`/`ram_addr` and the tristate data bus, and returns the selected 10-bit word.
- Keeps a one-entry pair buffer so a read of the other word of the last fetched pair completes without a RAM access.

---
 rtl/ram_bus_ctrl.sv | 136 +++++++++++++
 tb/tb_ram_bus_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bus_ctrl.sv
// ram_bus_ctrl: bus master for the word-pair RAM.
// Takes single-word read/write requests over valid/ready, drives the
// shared tristate pair bus, and keeps the last fetched pair in a one-entry
// buffer so that a read of its sibling word skips the RAM access.
module ram_bus_ctrl #(
  parameter int ADDR_W = 10,
  parameter int WORD_W = 10,
  parameter bit BUF_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [WORD_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [WORD_W-1:0]     rsp_rdata,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic                  ram_we,
  inout  wire  [2*WORD_W-1:0]   ram_data,
  output logic [15:0]           stat_hits
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

  state_t                r_state, w_next;
  logic                  r_we_l;
  logic [ADDR_W-1:0]     r_addr_l;
  logic [WORD_W-1:0]     r_wdata_l;
  logic                  r_ram_we;
  logic [ADDR_W-1:0]     r_ram_addr;
  logic                  r_rsp_valid;
  logic [WORD_W-1:0]     r_rsp_rdata;
  logic [15:0]           r_hits;
  logic                  r_buf_vld;
  logic [ADDR_W-2:0]     r_buf_tag;
  logic [2*WORD_W-1:0]   r_buf_data;
  logic                  w_hit;
  logic                  w_tag_match_l;

  // Read hit: buffered pair matches the incoming request's pair tag
  assign w_hit = BUF_EN && r_buf_vld && !req_we &&
                 (r_buf_tag == req_addr[ADDR_W-1:1]);
  // Latched request still falls in the buffered pair (write-through check)
  assign w_tag_match_l = r_buf_vld && (r_buf_tag == r_addr_l[ADDR_W-1:1]);

  // Controller drives the bus only while writing; RAM drives it otherwise
  assign ram_data  = r_ram_we ? {r_wdata_l, r_wdata_l} : {(2*WORD_W){1'bz}};
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign stat_hits = r_hits;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req_valid) begin
        if (req_we)     w_next = S_WR;
        else if (w_hit) w_next = S_RESP;
        else            w_next = S_RD;
      end
      S_RD:   w_next = S_RESP;
      S_WR:   w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake output: accept only while idle
  always_comb begin
    req_ready = (r_state == S_IDLE);
  end

  // Datapath: request latch, RAM control, pair buffer, response, hit counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we_l      <= 1'b0;
      r_addr_l    <= '0;
      r_wdata_l   <= '0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_hits      <= '0;
      r_buf_vld   <= 1'b0;
      r_buf_tag   <= '0;
      r_buf_data  <= '0;
    end else begin
      r_rsp_valid <= (w_next == S_RESP);
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_we_l    <= req_we;
          r_addr_l  <= req_addr;
          r_wdata_l <= req_wdata;
          if (req_we) begin
            r_ram_addr <= req_addr;
            r_ram_we   <= 1'b1;
          end else if (w_hit) begin
            r_rsp_rdata <= req_addr[0] ? r_buf_data[2*WORD_W-1:WORD_W]
                                       : r_buf_data[WORD_W-1:0];
            r_hits      <= r_hits + 16'd1;
          end else begin
            r_ram_addr <= req_addr;
            r_ram_we   <= 1'b0;
          end
        end
        S_RD: begin
          r_buf_data  <= ram_data;
          r_buf_tag   <= r_addr_l[ADDR_W-1:1];
          r_buf_vld   <= 1'b1;
          r_rsp_rdata <= r_addr_l[0] ? ram_data[2*WORD_W-1:WORD_W]
                                     : ram_data[WORD_W-1:0];
        end
        S_WR: begin
          r_ram_we    <= 1'b0;
          r_rsp_rdata <= r_wdata_l;
          if (w_tag_match_l) begin
            if (r_addr_l[0]) r_buf_data[2*WORD_W-1:WORD_W] <= r_wdata_l;
            else             r_buf_data[WORD_W-1:0]        <= r_wdata_l;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bus_ctrl.sv
// Bench for ram_bus_ctrl: word-pair RAM model on the shared bus, a table of
// directed vectors, hand-written reset/back-to-back sequences, and random
// requests checked against a memory + last-pair model.
module tb_ram_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [9:0]  req_wdata = '0;
  logic        rsp_valid;
  logic [9:0]  rsp_rdata;
  logic [9:0]  ram_addr;
  logic        ram_we;
  wire  [19:0] ram_data;
  logic [15:0] stat_hits;

  ram_bus_ctrl #(.ADDR_W(10), .WORD_W(10), .BUF_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_data(ram_data),
    .stat_hits(stat_hits)
  );

  always #5 clk = ~clk;

  // RAM model: drives the aligned pair when ram_we=0, commits one half on write
  logic [9:0] mem [0:1023];
  logic       pl_en = 1'b0;
  logic [9:0] pl_a = '0, pl_d = '0;
  assign ram_data = ram_we ? 20'bz : {mem[{ram_addr[9:1], 1'b1}], mem[{ram_addr[9:1], 1'b0}]};
  always @(posedge clk) begin
    if (pl_en)       mem[pl_a] <= pl_d;
    else if (ram_we) mem[ram_addr] <= ram_addr[0] ? ram_data[19:10] : ram_data[9:0];
  end

  int n_vec = 0, n_err = 0;

  // Reference model: memory contents plus identity of the last fetched pair
  logic [9:0] exp_mem [0:1023];
  bit         m_vld = 0;
  logic [8:0] m_pair = '0;
  int         m_hits = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model(input bit we, input logic [9:0] a, input logic [9:0] wd,
                       output logic [9:0] ed, output int el);
    if (we) begin
      exp_mem[a] = wd; ed = wd; el = 2;
    end else if (m_vld && m_pair == a[9:1]) begin
      ed = exp_mem[a]; el = 1; m_hits = (m_hits + 1) % 65536;
    end else begin
      ed = exp_mem[a]; el = 2; m_vld = 1; m_pair = a[9:1];
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [9:0] d);
    @(negedge clk); pl_en = 1'b1; pl_a = a; pl_d = d;
    @(posedge clk); #1 pl_en = 1'b0;
    exp_mem[a] = d;
  endtask

  task automatic apply_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    m_vld = 0; m_hits = 0;
  endtask

  // One request from IDLE; lat = cycles from accept edge to rsp_valid (0 = none)
  task automatic do_req(input bit we, input logic [9:0] a, input logic [9:0] wd,
                        output logic [9:0] d, output int lat, output int wec,
                        output logic [19:0] bus);
    int waitc;
    d = '0; lat = 0; wec = 0; bus = '0; waitc = 0;
    @(negedge clk);
    req_we = we; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    while (!req_ready && waitc < 10) begin @(negedge clk); waitc++; end
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (ram_we) begin wec++; bus = ram_data; end
      if (rsp_valid) begin lat = c; d = rsp_rdata; break; end
      @(negedge clk);
    end
  endtask

  // Issue a request and check it against the model's prediction
  task automatic model_req(input string tag, input bit we, input logic [9:0] a, input logic [9:0] wd);
    logic [9:0] d, ed; logic [19:0] bus; int lat, wec, el;
    model(we, a, wd, ed, el);
    do_req(we, a, wd, d, lat, wec, bus);
    chk({tag, " data"}, d, ed);
    chk({tag, " latency"}, lat, el);
    chk({tag, " hits"}, stat_hits, m_hits);
  endtask

  typedef struct {
    bit         rst;
    bit         we;
    logic [9:0] a;
    logic [9:0] wd;
    logic [9:0] ed;
    int         lat;
    int         hits;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic [9:0] d, ed; logic [19:0] bus; int lat, wec, el;
    int pulses[$]; int acc, lowcnt; bit rdy;

    tbl[0]  = '{1, 0, 10,   0,   5, 2, 0};
    tbl[1]  = '{0, 0, 11,   0,   3, 1, 1};
    tbl[2]  = '{1, 0, 10,   0,   5, 2, 0};
    tbl[3]  = '{0, 1, 11,   9,   9, 2, 0};
    tbl[4]  = '{0, 0, 11,   0,   9, 1, 1};
    tbl[5]  = '{0, 0, 10,   0,   5, 1, 2};
    tbl[6]  = '{0, 0, 0,    0,  10, 2, 2};
    tbl[7]  = '{0, 0, 1,    0, 576, 1, 3};
    tbl[8]  = '{0, 0, 2,    0, 331, 2, 3};
    tbl[9]  = '{0, 0, 1,    0, 576, 2, 3};
    tbl[10] = '{0, 0, 1023, 0, 100, 2, 3};
    tbl[11] = '{0, 0, 1022, 0, 200, 1, 4};
    tbl[12] = '{0, 1, 1022, 77, 77, 2, 4};

    for (int i = 0; i < 1024; i++) exp_mem[i] = '0;
    // Preload under reset; everything else in memory reads as the model's default
    for (int i = 0; i < 16; i++) preload(10'(i), 10'($urandom_range(0, 1023)));
    for (int i = 1016; i < 1024; i++) preload(10'(i), 10'($urandom_range(0, 1023)));
    preload(10, 5); preload(11, 3); preload(12, 0);
    preload(0, 10); preload(1, 576); preload(2, 331);
    preload(1023, 100); preload(1022, 200);

    @(negedge clk); reset = 1'b0;
    chk("reset ready", req_ready, 1);
    chk("reset ram_we", ram_we, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rdata", rsp_rdata, 0);
    chk("reset hits", stat_hits, 0);
    chk("reset ram_addr", ram_addr, 0);

    // Directed table: miss/hit, write coherence, miss replacement, pair 1022/1023
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].rst) apply_reset();
      model(tbl[i].we, tbl[i].a, tbl[i].wd, ed, el);
      do_req(tbl[i].we, tbl[i].a, tbl[i].wd, d, lat, wec, bus);
      chk($sformatf("vec%0d data", i), d, tbl[i].ed);
      chk($sformatf("vec%0d latency", i), lat, tbl[i].lat);
      chk($sformatf("vec%0d hits", i), stat_hits, tbl[i].hits);
      chk($sformatf("vec%0d we cycles", i), wec, tbl[i].we ? 1 : 0);
      if (tbl[i].we) chk($sformatf("vec%0d bus", i), bus, {tbl[i].wd, tbl[i].wd});
    end

    // Asynchronous reset in the middle of a WR cycle
    @(negedge clk);
    req_we = 1'b1; req_addr = 10'd5; req_wdata = 10'd1; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    chk("wr ram_we before reset", ram_we, 1);
    #1 reset = 1'b1;
    #1;
    chk("async reset ram_we", ram_we, 0);
    chk("async reset rsp_valid", rsp_valid, 0);
    chk("async reset hits", stat_hits, 0);
    chk("async reset ready", req_ready, 1);
    m_vld = 0; m_hits = 0;
    @(negedge clk); reset = 1'b0;
    chk("released bus", ram_data, {exp_mem[1], exp_mem[0]});

    // Reset in the RD cycle: no response, and the buffer is not filled
    preload(11, 3);
    @(negedge clk);
    req_we = 1'b0; req_addr = 10'd10; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0; reset = 1'b1;
    acc = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) reset = 1'b0;
      if (rsp_valid) acc++;
      @(negedge clk);
    end
    chk("aborted read pulses", acc, 0);
    m_vld = 0; m_hits = 0;
    do_req(0, 11, 0, d, lat, wec, bus);
    model(0, 11, 0, ed, el);
    chk("post-abort data", d, 3);
    chk("post-abort latency", lat, 2);

    // Back-to-back: read 10 (miss) held, write 12 queued behind it
    model_req("refill 0", 0, 0, 0);
    pulses.delete(); acc = 0; lowcnt = 0;
    @(negedge clk);
    req_we = 1'b0; req_addr = 10'd10; req_wdata = '0; req_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (acc == 1) begin req_we = 1'b1; req_addr = 10'd12; req_wdata = 10'd7; end
      else if (acc >= 2) req_valid = 1'b0;
      if (rsp_valid) pulses.push_back(int'(rsp_rdata));
      rdy = req_ready;
      if (acc == 1 && !rdy) lowcnt++;
      @(posedge clk);
      if (rdy && req_valid) acc++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    model(0, 10, 0, ed, el);
    model(1, 12, 7, ed, el);
    chk("b2b accepted", acc, 2);
    chk("b2b ready-low cycles", lowcnt, 2);
    chk("b2b pulse count", pulses.size(), 2);
    if (pulses.size() == 2) begin
      chk("b2b first rdata", pulses[0], 5);
      chk("b2b second rdata", pulses[1], 7);
    end
    model_req("read 12", 0, 12, 0);

    // Random requests against the model
    apply_reset();
    for (int i = 0; i < 80; i++) begin
      logic [9:0] a;
      bit we;
      a  = ($urandom_range(0, 3) == 0) ? 10'(1020 + $urandom_range(0, 3))
                                       : 10'($urandom_range(0, 7));
      we = ($urandom_range(0, 3) == 0);
      model_req($sformatf("rnd%0d", i), we, a, 10'($urandom_range(0, 1023)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
